// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the datapath hazard sources and pipe_ctrl_fsm.
// dm_req/dm_ack: MEM holds dm_req for an access until the cycle memory raises dm_ack; that ack cycle completes it.
interface pipe_ctrl_if;
    logic       pc_sel;
    logic       ex_mem_rd;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs2;
    logic       dm_req;
    logic       dm_ack;
    logic       pc_en;
    logic       stall_id;
    logic       stall_ex;
    logic       stall_mem;
    logic       bubble_ex;
    logic       flush_ex;
    logic       flush_id;
    logic [1:0] state;

    modport master (
        output pc_sel, ex_mem_rd, ex_rd, id_rs1, id_rs2, id_use_rs2, dm_req, dm_ack,
        input  pc_en, stall_id, stall_ex, stall_mem, bubble_ex, flush_ex, flush_id, state
    );

    modport slave (
        input  pc_sel, ex_mem_rd, ex_rd, id_rs1, id_rs2, id_use_rs2, dm_req, dm_ack,
        output pc_en, stall_id, stall_ex, stall_mem, bubble_ex, flush_ex, flush_id, state
    );
endinterface

// File: rtl/pipe_ctrl_fsm.sv
// Five-stage pipeline hazard controller: memory stalls, branch flushes and load-use bubbles.
// Define PIPE_CTRL_PERF_CNT_EN to add saturating stall_cnt/flush_cnt performance counters.
module pipe_ctrl_fsm #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b10,
        MEM_WAIT = 2'b11
    } state_t;

    state_t     r_state;
    logic [2:0] r_flush_left;

    state_t     w_next_state;
    logic [2:0] w_next_left;
    logic       w_lu;
    logic       w_mem_stall;
    logic       w_pc_en;
    logic       w_stall_id;
    logic       w_stall_ex;
    logic       w_stall_mem;
    logic       w_bubble_ex;
    logic       w_flush_ex;
    logic       w_flush_id;

    always_comb begin
        w_lu = bus.ex_mem_rd && (bus.ex_rd != 5'd0) &&
               ((bus.ex_rd == bus.id_rs1) || (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
        w_mem_stall  = bus.dm_req && !bus.dm_ack;
        w_pc_en      = 1'b1;
        w_stall_id   = 1'b0;
        w_stall_ex   = 1'b0;
        w_stall_mem  = 1'b0;
        w_bubble_ex  = 1'b0;
        w_flush_ex   = 1'b0;
        w_flush_id   = 1'b0;
        w_next_state = RUN;
        w_next_left  = 3'd0;
        if (rst) begin
            // Reset squashes whatever is in IF/ID and ID/EX and freezes the PC.
            w_pc_en    = 1'b0;
            w_flush_ex = 1'b1;
            w_flush_id = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        w_pc_en      = 1'b0;
                        w_stall_id   = 1'b1;
                        w_stall_ex   = 1'b1;
                        w_stall_mem  = 1'b1;
                        w_next_state = MEM_WAIT;
                    end else if (bus.pc_sel) begin
                        // A coincident load-use is dropped: flush_id kills the dependent instruction.
                        w_flush_ex = 1'b1;
                        w_flush_id = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state = FLUSH;
                            w_next_left  = 3'(FLUSH_CYCLES - 1);
                        end
                    end else if (w_lu) begin
                        w_pc_en     = 1'b0;
                        w_stall_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.dm_ack) begin
                        w_pc_en      = 1'b0;
                        w_stall_id   = 1'b1;
                        w_stall_ex   = 1'b1;
                        w_stall_mem  = 1'b1;
                        w_next_state = MEM_WAIT;
                    end
                end
                FLUSH: begin
                    w_flush_id = 1'b1;
                    if (r_flush_left > 3'd1) begin
                        w_next_state = FLUSH;
                        w_next_left  = r_flush_left - 3'd1;
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_left <= 3'd0;
        end else begin
            r_state      <= w_next_state;
            r_flush_left <= w_next_left;
        end
    end

    assign bus.pc_en     = w_pc_en;
    assign bus.stall_id  = w_stall_id;
    assign bus.stall_ex  = w_stall_ex;
    assign bus.stall_mem = w_stall_mem;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.flush_ex  = w_flush_ex;
    assign bus.flush_id  = w_flush_id;
    assign bus.state     = r_state;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_id && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed and randomized checks of pipe_ctrl_fsm against a rule-level reference model.
module tb_pipe_ctrl_fsm;
    localparam int FLUSH_CYCLES = 3;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Output vector order: {pc_en, stall_id, stall_ex, stall_mem, bubble_ex, flush_ex, flush_id, state}
    localparam logic [8:0] V_IDLE  = 9'b1_000_0_00_00;
    localparam logic [8:0] V_LU    = 9'b0_100_1_00_00;
    localparam logic [8:0] V_BR    = 9'b1_000_0_11_00;
    localparam logic [8:0] V_FLUSH = 9'b1_000_0_01_10;
    localparam logic [8:0] V_MSRUN = 9'b0_111_0_00_00;
    localparam logic [8:0] V_MSW   = 9'b0_111_0_00_11;
    localparam logic [8:0] V_ACK   = 9'b1_000_0_00_11;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    pipe_ctrl_fsm #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] obs_v;
    assign obs_v = {bus.pc_en, bus.stall_id, bus.stall_ex, bus.stall_mem,
                    bus.bubble_ex, bus.flush_ex, bus.flush_id, bus.state};

    // Reference model: a pending memory wait, and a number of extra flush cycles still owed.
    bit m_wait;
    int m_flush_left;
    int m_stall_cnt;
    int m_flush_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit ps, input bit mr,
                        input logic [4:0] erd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u2, input bit dr, input bit da);
        bit         lu;
        logic [1:0] exp_state;
        logic [8:0] exp_v;
        @(negedge clk);
        rst            = r;
        bus.pc_sel     = ps;
        bus.ex_mem_rd  = mr;
        bus.ex_rd      = erd;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
        bus.dm_req     = dr;
        bus.dm_ack     = da;
        #1;
        lu        = mr && (erd != 0) && ((erd == rs1) || (u2 && (erd == rs2)));
        exp_state = (m_flush_left > 0) ? 2'b10 : (m_wait ? 2'b11 : 2'b00);
        if (r)                 exp_v = {7'b0_000_0_11, exp_state};
        else if (m_wait)       exp_v = {(da ? 7'b1_000_0_00 : 7'b0_111_0_00), exp_state};
        else if (m_flush_left > 0) exp_v = {7'b1_000_0_01, exp_state};
        else if (dr && !da)    exp_v = {7'b0_111_0_00, exp_state};
        else if (ps)           exp_v = {7'b1_000_0_11, exp_state};
        else if (lu)           exp_v = {7'b0_100_1_00, exp_state};
        else                   exp_v = {7'b1_000_0_00, exp_state};
        check(tag, 32'(obs_v), 32'(exp_v));
`ifdef PIPE_CTRL_PERF_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall_cnt));
        check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush_cnt));
`endif
        // Advance the model to the state after the coming rising edge.
        if (r) begin
            m_wait = 0; m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (exp_v[8] == 1'b0 && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (exp_v[2] == 1'b1 && m_flush_cnt < CNT_MAX) m_flush_cnt++;
            if (m_wait)                m_wait = !da;
            else if (m_flush_left > 0) m_flush_left--;
            else if (dr && !da)        m_wait = 1;
            else if (ps)               m_flush_left = FLUSH_CYCLES - 1;
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        checks = 0; failures = 0;
        m_wait = 0; m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        rst = 1'b1;
        bus.pc_sel = 0; bus.ex_mem_rd = 0; bus.ex_rd = 0; bus.id_rs1 = 0;
        bus.id_rs2 = 0; bus.id_use_rs2 = 0; bus.dm_req = 0; bus.dm_ack = 0;

        // Reset
        step("rst0", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("rst1", 1, 1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0);
        check("rst_lit", 32'(obs_v), 32'(9'b0_000_0_11_00));
        idle("idle0");
        check("idle_lit", 32'(obs_v), 32'(V_IDLE));

        // Load-use on rs1
        step("lu_rs1", 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        check("lu_lit", 32'(obs_v), 32'(V_LU));
        idle("lu_after");
        check("lu_after_lit", 32'(obs_v), 32'(V_IDLE));

        // No hazard: x0 destination, and unused rs2 match
        step("lu_x0", 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        check("lu_x0_lit", 32'(obs_v), 32'(V_IDLE));
        step("lu_rs2_unused", 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
        check("lu_rs2_unused_lit", 32'(obs_v), 32'(V_IDLE));
        step("lu_rs2_used", 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);

        // Branch flush
        step("br", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("br_lit", 32'(obs_v), 32'(V_BR));
        step("fl1", 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
        check("fl1_lit", 32'(obs_v), 32'(V_FLUSH));
        idle("fl2");
        check("fl2_lit", 32'(obs_v), 32'(V_FLUSH));
        idle("fl_done");
        check("fl_done_lit", 32'(obs_v), 32'(V_IDLE));

        // Memory stall 4 cycles, then ack
        step("ms0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        check("ms0_lit", 32'(obs_v), 32'(V_MSRUN));
        for (int i = 1; i < 4; i++) begin
            step("msw", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
            check("msw_lit", 32'(obs_v), 32'(V_MSW));
        end
        step("ms_ack", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        check("ms_ack_lit", 32'(obs_v), 32'(V_ACK));
        idle("ms_done");
        check("ms_done_lit", 32'(obs_v), 32'(V_IDLE));

        // Memory stall beats branch and load-use; branch re-presented afterwards
        step("pri0", 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0);
        check("pri0_lit", 32'(obs_v), 32'(V_MSRUN));
        step("pri1", 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0);
        check("pri1_lit", 32'(obs_v), 32'(V_MSW));
        step("pri_ack", 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 1);
        check("pri_ack_lit", 32'(obs_v), 32'(V_ACK));
        step("pri_br", 0, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
        check("pri_br_lit", 32'(obs_v), 32'(V_BR));
        idle("pri_fl1");
        idle("pri_fl2");
        idle("pri_done");

        // Reset during the 2nd MEM_WAIT cycle, with a dm_ack that must be dropped
        step("rmw0", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step("rmw1", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        step("rmw_rst", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        check("rmw_rst_lit", 32'(obs_v), 32'(9'b0_000_0_11_11));
        idle("rmw_after");
        check("rmw_after_lit", 32'(obs_v), 32'(V_IDLE));

        // Reset mid-FLUSH
        step("rfl_br", 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("rfl_rst", 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        check("rfl_rst_lit", 32'(obs_v), 32'(9'b0_000_0_11_10));
        idle("rfl_after");
        check("rfl_after_lit", 32'(obs_v), 32'(V_IDLE));

        // Five stall cycles after reset: a 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) step("sat_lu", 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, 0);
        idle("sat_idle");
`ifdef PIPE_CTRL_PERF_CNT_EN
        check("sat_stall_cnt_lit", 32'(stall_cnt), 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
